adder_8_seq_ctrl: RTL and testbench
===================================

Name: adder_8_seq_ctrl

Overview:
Sequencer that performs NBYTES-wide add/subtract by time-multiplexing a single 8-bit ripple adder, one byte per cycle, least significant byte first, with the carry registered between bytes. It takes operand/result traffic over valid/ready handshakes. It sits between a requesting datapath and the existing 8-bit adder, trading latency for area on wide arithmetic.

Parameters:
NBYTES, 4, operand width in bytes (legal range 2..16); total width W = 8*NBYTES

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  controller can accept a request
op_a  input  W  operand A
op_b  input  W  operand B
sub  input  1  1 = A - B, 0 = A + B + cin
cin  input  1  carry-in for add; ignored when sub=1
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  sum/difference
cout  output  1  final carry out (for sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, out_valid=0, result=0, cout=0, overflow=0, busy=0, byte index=0, carry reg=0. in_ready=1 once in IDLE.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at a rising edge:
  - capture op_a into A reg; capture op_b (sub=0) or ~op_b (sub=1) into B reg.
  - carry reg <= sub ? 1 : cin. Index <= 0. Go to RUN.
- RUN: in_ready=0, busy=1.
  - Each cycle the adder sees A byte[idx], B byte[idx] and carry reg.
  - On the edge, the sum is written into result byte[idx], carry reg <= adder cout, idx <= idx+1.
  - On the edge where idx==NBYTES-1: cout <= adder cout, then go to DONE.
  - overflow <= (A[W-1]==B_eff[W-1]) && (sum bit 7 != A[W-1]), where B_eff is the registered, possibly inverted B.
- Latency: acceptance edge at cycle 0 → out_valid high after edge NBYTES, i.e. exactly NBYTES cycles after acceptance.
- DONE: out_valid=1, busy=1. result, cout and overflow are held stable until out_valid&&out_ready at an edge, then go to IDLE with out_valid=0.
  - result/cout/overflow keep their last values in IDLE until the next computation overwrites them.
- No request overlap: in_ready is 0 in RUN and DONE. A new request is accepted at the earliest one cycle after the result handshake; there is no same-cycle out→in bypass.
- in_valid asserted while not ready: request is ignored and not captured; the requester must hold it.
- The intermediate result register is partially updated during RUN. Consumers use result only when out_valid=1.
- Reset mid-RUN or mid-DONE: immediate return to reset values, in-flight operation discarded, no out_valid pulse.
- Arithmetic is modulo 2^W. Subtraction is A + ~B + 1, so cout=0 indicates a borrow.
- Index counter width is clog2(NBYTES). No wrap occurs because the transition to DONE happens at NBYTES-1.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE) and constant BYTE_W=8.
- Sub-module: one instance of the existing adder_8 as the byte datapath; the controller contains no adder logic of its own.
- Byte select is a mux on the A/B registers (or a shift-right-by-8 each RUN cycle; either is acceptable).

Test Plan:
1. NBYTES=4, A=0x000000FF, B=0x00000001, sub=0, cin=0 → result=0x00000100, cout=0, overflow=0; out_valid exactly 4 cycles after acceptance.
2. A=0xFFFFFFFF, B=0x00000000, cin=1 → result=0x00000000, cout=1, overflow=0 (carry ripples through all bytes).
3. sub=1, A=0x00000005, B=0x00000007 → result=0xFFFFFFFE, cout=0 (borrow), overflow=0; cin=1 during this request has no effect.
4. A=0x7FFFFFFF, B=0x00000001, sub=0 → result=0x80000000, overflow=1, cout=0. Then sub=1, A=0x80000000, B=0x00000001 → 0x7FFFFFFF, overflow=1, cout=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE → result/cout/overflow stable, in_ready=0, a second in_valid is not accepted. Raise out_ready → IDLE next cycle; the second request is accepted the cycle after.
6. Assert rst_n=0 during the 2nd RUN cycle → outputs return to reset values asynchronously, no out_valid. After release, a fresh request 0x12345678+0x11111111 → 0x23456789, cout=0.

Source files
------------

// File: rtl/adder_8_seq_ctrl_pkg.sv
// rtl/adder_8_seq_ctrl_pkg.sv - shared types and constants for the byte-serial add/sub sequencer
package adder_8_seq_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement overflow from the sign bits of both addends and of the sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_8_seq_ctrl_if.sv
// rtl/adder_8_seq_ctrl_if.sv - request/result handshake bundle of the sequencer
interface adder_8_seq_ctrl_if
    import adder_8_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) ();
    localparam int W = BYTE_W * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, op_a, op_b, sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, overflow, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, cin, out_ready,
        output in_ready, out_valid, result, cout, overflow, busy
    );

endinterface

// File: rtl/adder_8_seq_ctrl_adder_8.sv
// rtl/adder_8_seq_ctrl_adder_8.sv - the existing 8-bit ripple-carry adder used as the byte datapath
module adder_8
    import adder_8_seq_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[BYTE_W];
    end

endmodule

// File: rtl/adder_8_seq_ctrl.sv
// rtl/adder_8_seq_ctrl.sv - NBYTES-wide add/subtract sequenced LSB-first through one 8-bit adder
module adder_8_seq_ctrl
    import adder_8_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_8_seq_ctrl_if.slave   bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [IDX_W+2:0]   bit_base;
    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  sum_byte;
    logic               add_cout;
    logic               last_byte;

    // Byte lane of the operand registers currently feeding the adder.
    assign bit_base  = {idx_q, 3'b000};
    assign a_byte    = a_q[bit_base +: BYTE_W];
    assign b_byte    = b_q[bit_base +: BYTE_W];
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    adder_8 u_adder_8 (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (sum_byte),
        .cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[bit_base +: BYTE_W] = sum_byte;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    // Top byte: its bit 7 is the sign of the full-width sum.
                    cout_d  = add_cout;
                    ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], sum_byte[BYTE_W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_adder_8_seq_ctrl.sv
// tb/tb_adder_8_seq_ctrl.sv - directed vector bench for adder_8_seq_ctrl
module tb_adder_8_seq_ctrl;
    import adder_8_seq_ctrl_pkg::*;

    localparam int NB = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_8_seq_ctrl_if #(.NBYTES(NB)) bus ();

    adder_8_seq_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        c;
        logic [31:0] exp_res;
        logic        exp_cout;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c);
        int w;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 20);
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_take", {31'b0, bus.out_valid}, 32'd0);
        check("in_ready_after_take", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic check_out(input string name, input logic [31:0] r, input logic c, input logic o);
        check({name, "_result"}, bus.result, r);
        check({name, "_cout"}, {31'b0, bus.cout}, {31'b0, c});
        check({name, "_overflow"}, {31'b0, bus.overflow}, {31'b0, o});
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({name, "_result"}, bus.result, 32'd0);
        check({name, "_cout"}, {31'b0, bus.cout}, 32'd0);
        check({name, "_overflow"}, {31'b0, bus.overflow}, 32'd0);
        check({name, "_busy"}, {31'b0, bus.busy}, 32'd0);
        check({name, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        logic seen_valid;
        checks = 0;
        errors = 0;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, "add_ff_1"};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, "ripple_cin"};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow"};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "add_ovf"};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf"};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, "add_neg_ovf"};
        vecs[6] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, "sub_pos"};
        vecs[7] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, "add_mixed"};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
            check({vecs[i].name, "_busy"}, {31'b0, bus.busy}, 32'd1);
            wait_done(cyc);
            check({vecs[i].name, "_latency"}, cyc, NB);
            check_out(vecs[i].name, vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_ovf);
            take_result();
        end

        // Backpressure: result held in DONE while a second request waits.
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        wait_done(cyc);
        check("bp_latency", cyc, NB);
        bus.op_a     = 32'h00000001;
        bus.op_b     = 32'h00000002;
        bus.sub      = 1'b0;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check_out("bp_hold", 32'h23456789, 1'b0, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("bp_idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("bp_idle_busy", {31'b0, bus.busy}, 32'd0);
        check("bp_idle_result_kept", bus.result, 32'h23456789);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_second_busy", {31'b0, bus.busy}, 32'd1);
        wait_done(cyc);
        check("bp_second_latency", cyc, NB);
        check_out("bp_second", 32'h00000003, 1'b0, 1'b0);
        take_result();

        // Asynchronous reset in the second RUN cycle.
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("rst_partial_byte0", {24'b0, bus.result[7:0]}, 32'h00000089);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun_reset");
        seen_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen_valid = seen_valid | bus.out_valid;
        end
        check("midrun_no_out_valid", {31'b0, seen_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        wait_done(cyc);
        check("post_reset_latency", cyc, NB);
        check_out("post_reset", 32'h23456789, 1'b0, 1'b0);
        take_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
